// File: rtl/line_writer.sv
// line_writer: packs character pairs into line memory and commits each line's {len,start} to a pointer table
// Ports: clk, rst (async, active-high); line_begin/line_idx open a line; in_valid/in_ready/lhs_in/rhs_in/in_last stream pairs;
// mem_we/mem_addr/mem_din write line memory; ptr_we/ptr_idx/ptr_data write the pointer table; clear frees memory;
// busy, overflow (sticky), empty_err (pulse) and which_state report status.
module line_writer #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        line_begin,
  input  logic [7:0]  line_idx,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  lhs_in,
  input  logic [7:0]  rhs_in,
  input  logic        in_last,
  output logic        mem_we,
  output logic [9:0]  mem_addr,
  output logic [15:0] mem_din,
  output logic        ptr_we,
  output logic [7:0]  ptr_idx,
  output logic [19:0] ptr_data,
  input  logic        clear,
  output logic        busy,
  output logic        overflow,
  output logic        empty_err,
  output logic [3:0]  which_state
);
  typedef enum logic [1:0] {IDLE, WRITE, COMMIT, DROP} state_t;
  state_t state, state_nx;
  logic [10:0] wr_ptr, count, start;
  logic [7:0]  line_q;
  logic        full, acc;
  assign full        = wr_ptr >= 11'(MEM_WORDS);
  assign in_ready    = (state == WRITE) && !full;
  assign acc         = in_valid && in_ready;
  assign busy        = state != IDLE;
  assign which_state = {2'b00, state};
  assign ptr_we      = (state == COMMIT) && (count != 11'd0);
  assign empty_err   = (state == COMMIT) && (count == 11'd0);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = line_begin ? WRITE : IDLE;
      WRITE:   state_nx = (acc && in_last) ? COMMIT : (in_valid && full) ? DROP : WRITE;
      COMMIT:  state_nx = IDLE;
      DROP:    state_nx = (in_valid && in_last) ? IDLE : DROP;
      default: state_nx = IDLE;
    endcase
  end
  // The pointer entry is loaded on the edge that accepts the last pair, so it is
  // already valid during COMMIT; count before that increment equals final count-1.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr   <= '0;
      count    <= '0;
      start    <= '0;
      line_q   <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      ptr_idx  <= '0;
      ptr_data <= '0;
      overflow <= 1'b0;
    end else begin
      mem_we <= acc;
      if (acc) begin
        mem_addr <= wr_ptr[9:0];
        mem_din  <= {lhs_in, rhs_in};
        wr_ptr   <= wr_ptr + 11'd1;
        count    <= count + 11'd1;
      end
      if (acc && in_last) begin
        ptr_idx  <= line_q;
        ptr_data <= {count[9:0], start[9:0]};
      end
      if (state == IDLE && line_begin) begin
        line_q <= line_idx;
        start  <= wr_ptr;
        count  <= '0;
      end else if (state == IDLE && clear) begin
        wr_ptr   <= '0;
        overflow <= 1'b0;
      end
      if (state == WRITE && in_valid && full) overflow <= 1'b1;
      if (state == DROP && in_valid && in_last) wr_ptr <= start;
    end
endmodule

// File: tb/tb_line_writer.sv
// tb_line_writer: directed-vector bench for line_writer (default and MEM_WORDS=4 instances share stimulus)
module tb_line_writer;
  logic clk = 1'b0, rst = 1'b1;
  logic line_begin = 0, in_valid = 0, in_last = 0, clear = 0;
  logic [7:0] line_idx = 0, lhs_in = 0, rhs_in = 0;
  logic in_ready, mem_we, ptr_we, busy, overflow, empty_err;
  logic [9:0] mem_addr;
  logic [15:0] mem_din;
  logic [7:0] ptr_idx;
  logic [19:0] ptr_data;
  logic [3:0] which_state;
  logic rdy4, we4, pwe4, busy4, ov4, ee4;
  logic [9:0] addr4;
  logic [15:0] din4;
  logic [7:0] pidx4;
  logic [19:0] pdata4;
  logic [3:0] ws4;
  int n_vec = 0, n_bad = 0, ptr_cnt = 0, ptr4_cnt = 0, ee_cnt = 0;

  line_writer dut (
    .clk(clk), .rst(rst), .line_begin(line_begin), .line_idx(line_idx),
    .in_valid(in_valid), .in_ready(in_ready), .lhs_in(lhs_in), .rhs_in(rhs_in), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .ptr_we(ptr_we), .ptr_idx(ptr_idx), .ptr_data(ptr_data),
    .clear(clear), .busy(busy), .overflow(overflow), .empty_err(empty_err), .which_state(which_state)
  );

  line_writer #(.MEM_WORDS(4)) dut4 (
    .clk(clk), .rst(rst), .line_begin(line_begin), .line_idx(line_idx),
    .in_valid(in_valid), .in_ready(rdy4), .lhs_in(lhs_in), .rhs_in(rhs_in), .in_last(in_last),
    .mem_we(we4), .mem_addr(addr4), .mem_din(din4),
    .ptr_we(pwe4), .ptr_idx(pidx4), .ptr_data(pdata4),
    .clear(clear), .busy(busy4), .overflow(ov4), .empty_err(ee4), .which_state(ws4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ptr_we) ptr_cnt++;
    if (pwe4) ptr4_cnt++;
    if (empty_err || ee4) ee_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic open_line(input logic [7:0] idx);
    line_begin = 1; line_idx = idx;
    tick;
    line_begin = 0;
  endtask

  task automatic pair(input logic [7:0] l, input logic [7:0] r, input logic last, input logic [9:0] a);
    in_valid = 1; lhs_in = l; rhs_in = r; in_last = last;
    tick;
    chk("pair_we", mem_we, 1);
    chk("pair_addr", mem_addr, a);
    chk("pair_din", mem_din, {l, r});
  endtask

  task automatic idle_in;
    in_valid = 0; in_last = 0;
  endtask

  int p0;

  initial begin
    #2;
    chk("rst_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_ptr", {ptr_we, ptr_idx, ptr_data}, 0);
    tick; tick;
    rst = 0;
    // basic three-pair line
    open_line(8'd5);
    chk("write_state", which_state, 1);
    chk("write_ready", in_ready, 1);
    pair("a", "A", 0, 10'd0);
    pair("b", "B", 0, 10'd1);
    pair("c", "C", 1, 10'd2);
    chk("l1_ptr_we", ptr_we, 1);
    chk("l1_ptr_idx", ptr_idx, 8'd5);
    chk("l1_ptr_data", ptr_data, 20'h00800);
    chk("l1_commit_state", which_state, 2);
    idle_in;
    tick;
    chk("l1_after_we", mem_we, 0);
    chk("l1_after_ptr", ptr_we, 0);
    chk("l1_after_state", which_state, 0);
    chk("l1_ptr_hold", ptr_data, 20'h00800);
    // single-pair line
    open_line(8'd6);
    pair("x", "X", 1, 10'd3);
    chk("l2_ptr_idx", ptr_idx, 8'd6);
    chk("l2_ptr_data", ptr_data, 20'h00003);
    idle_in;
    tick;
    // gaps in in_valid
    open_line(8'd7);
    tick;
    chk("gap1_we", mem_we, 0);
    tick;
    chk("gap2_we", mem_we, 0);
    pair("d", "D", 0, 10'd4);
    idle_in;
    tick;
    chk("gap3_we", mem_we, 0);
    pair("e", "E", 1, 10'd5);
    chk("l3_ptr_data", ptr_data, 20'h00404);
    idle_in;
    tick;
    chk("ptr_cnt_3", ptr_cnt, 3);
    // overflow on the 4-word instance
    rst = 1; tick; rst = 0;
    p0 = ptr4_cnt;
    open_line(8'd9);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; lhs_in = 8'h30 + 8'(i); rhs_in = 8'h40 + 8'(i); in_last = (i == 5);
      tick;
      if (i < 4) begin
        chk("ov_we", we4, 1);
        chk("ov_addr", addr4, 10'(i));
        chk("ov_din", din4, {8'h30 + 8'(i), 8'h40 + 8'(i)});
      end else chk("ov_nowrite", we4, 0);
      if (i == 4) begin
        chk("ov_flag", ov4, 1);
        chk("ov_drop_state", ws4, 3);
        chk("ov_drop_ready", rdy4, 0);
        chk("ov_drop_busy", busy4, 1);
      end
    end
    chk("ov_idle", ws4, 0);
    idle_in;
    tick;
    chk("ov_no_ptr", ptr4_cnt, p0);
    open_line(8'd10);
    in_valid = 1; lhs_in = "q"; rhs_in = "Q"; in_last = 1;
    tick;
    chk("ov_next_we", we4, 1);
    chk("ov_next_addr", addr4, 0);
    chk("ov_next_ptr", {pwe4, pidx4, pdata4}, {1'b1, 8'd10, 20'h00000});
    idle_in;
    tick;
    chk("ov_sticky", ov4, 1);
    clear = 1; tick; clear = 0;
    chk("ov_clear", ov4, 0);
    // reset mid-line
    rst = 1; tick; rst = 0;
    open_line(8'd3);
    pair("a", "A", 0, 10'd0);
    pair("b", "B", 0, 10'd1);
    p0 = ptr_cnt;
    rst = 1;
    #1;
    chk("mrst_mem", {mem_we, mem_addr, mem_din}, 0);
    chk("mrst_ptr", {ptr_we, ptr_idx, ptr_data}, 0);
    chk("mrst_status", {in_ready, busy, overflow, empty_err, which_state}, 0);
    idle_in;
    tick;
    rst = 0;
    tick;
    chk("mrst_no_ptr", ptr_cnt, p0);
    open_line(8'd4);
    pair("z", "Z", 1, 10'd0);
    idle_in;
    tick;
    // clear, then line_begin+clear together
    open_line(8'd8);
    pair("m", "M", 1, 10'd1);
    idle_in;
    tick;
    clear = 1; tick; clear = 0;
    open_line(8'd11);
    pair("n", "N", 1, 10'd0);
    idle_in;
    tick;
    clear = 1;
    open_line(8'd12);
    clear = 0;
    pair("o", "O", 1, 10'd1);
    chk("bc_ptr_data", ptr_data, 20'h00001);
    idle_in;
    tick;
    chk("no_empty_err", ee_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
